// File: rtl/mmio_periph_hub.sv
// Memory-mapped I/O hub for the CPU data port: address decode to DRAM or peripherals,
// display/LED registers, a debounced switch input and a prescaled compare timer.
module mmio_periph_hub #(
    parameter logic [31:0] IO_BASE    = 32'hFFFF_F000,
    parameter logic [31:0] DRAM_BASE  = 32'h0000_4000,
    parameter int          DRAM_AW    = 14,
    parameter int          LED_W      = 24,
    parameter int          SW_W       = 24,
    parameter int          DEB_CYCLES = 16,
    parameter int          TMR_DIV    = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               mem_we,
    output logic [31:0]        rdata,
    input  logic [31:0]        dram_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [SW_W-1:0]    switch,
    output logic [LED_W-1:0]   led,
    output logic [31:0]        seg_data,
    output logic               irq
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = (TMR_DIV > 1) ? $clog2(TMR_DIV) : 1;
    localparam logic [32:0]   DRAM_SIZE = 33'd4 << DRAM_AW;
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TMR_DIV - 1);

    localparam logic [11:0] OFF_SEG    = 12'h000;
    localparam logic [11:0] OFF_LED    = 12'h060;
    localparam logic [11:0] OFF_SW     = 12'h070;
    localparam logic [11:0] OFF_SWSTAT = 12'h074;
    localparam logic [11:0] OFF_TCNT   = 12'h080;
    localparam logic [11:0] OFF_TCMP   = 12'h084;
    localparam logic [11:0] OFF_TCTRL  = 12'h088;

    logic [31:0]      seg_q, seg_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_meta_d, sw_s_q, sw_s_d, sw_stable_q, sw_stable_d;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic             chg_q, chg_d;
    logic [31:0]      tcnt_q, tcnt_d, tcmp_q, tcmp_d;
    logic             en_q, en_d, ar_q, ar_d, ie_q, ie_d, match_q, match_d;
    logic [PW-1:0]    presc_q, presc_d;

    logic [31:0] dram_off;
    logic [11:0] off;
    logic        io_sel, dram_sel, io_we;
    logic        sw_accept, tick, match_hit;

    always_comb begin
        dram_off   = addr - DRAM_BASE;
        off        = addr[11:0];
        io_sel     = (addr[31:12] == IO_BASE[31:12]);
        // Unsigned offset compare also rejects addresses below DRAM_BASE (they wrap high).
        dram_sel   = ({1'b0, dram_off} < DRAM_SIZE);
        io_we      = mem_we & io_sel;
        dram_we    = mem_we & dram_sel & ~io_sel;
        dram_addr  = dram_off[DRAM_AW+1:2];
        dram_wdata = wdata;
        rdata      = 32'd0;
        if (io_sel) begin
            case (off)
                OFF_SEG:    rdata = seg_q;
                OFF_LED:    rdata = 32'(led_q);
                OFF_SW:     rdata = 32'(sw_stable_q);
                OFF_SWSTAT: rdata = {31'd0, chg_q};
                OFF_TCNT:   rdata = tcnt_q;
                OFF_TCMP:   rdata = tcmp_q;
                OFF_TCTRL:  rdata = {23'd0, match_q, 5'd0, ie_q, ar_q, en_q};
                default:    rdata = 32'd0;
            endcase
        end else if (dram_sel) begin
            rdata = dram_rdata;
        end
    end

    always_comb begin
        seg_d       = seg_q;
        led_d       = led_q;
        sw_meta_d   = switch;
        sw_s_d      = sw_meta_q;
        sw_stable_d = sw_stable_q;
        deb_cnt_d   = deb_cnt_q;
        chg_d       = chg_q;
        tcnt_d      = tcnt_q;
        tcmp_d      = tcmp_q;
        en_d        = en_q;
        ar_d        = ar_q;
        ie_d        = ie_q;
        match_d     = match_q;
        presc_d     = presc_q;

        if (io_we && off == OFF_SEG) seg_d = wdata;
        if (io_we && off == OFF_LED) led_d = wdata[LED_W-1:0];

        // deb_cnt restarts on the edge where sw_s takes a new value.
        if (sw_meta_q != sw_s_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_MAX) begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
        sw_accept = (deb_cnt_q == DEB_LAST) && (sw_s_q != sw_stable_q);
        if (sw_accept) begin
            sw_stable_d = sw_s_q;
            chg_d       = 1'b1;
        end else if (io_we && off == OFF_SWSTAT && wdata[0]) begin
            chg_d = 1'b0;
        end

        tick      = en_q && (presc_q == PRE_LAST);
        match_hit = tick && (tcnt_q == tcmp_q);
        if (tick) begin
            presc_d = '0;
            if (match_hit) begin
                tcnt_d = ar_q ? 32'd0 : tcnt_q;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end else if (en_q) begin
            presc_d = presc_q + PW'(1);
        end
        if (io_we && off == OFF_TCNT) tcnt_d = wdata;
        if (io_we && off == OFF_TCMP) tcmp_d = wdata;
        if (io_we && off == OFF_TCTRL) begin
            en_d = wdata[0];
            ar_d = wdata[1];
            ie_d = wdata[2];
            if (wdata[8]) match_d = 1'b0;
        end
        if (match_hit) match_d = 1'b1;
        if (!en_d) presc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= '0;
            led_q       <= '0;
            sw_meta_q   <= '0;
            sw_s_q      <= '0;
            sw_stable_q <= '0;
            deb_cnt_q   <= '0;
            chg_q       <= 1'b0;
            tcnt_q      <= '0;
            tcmp_q      <= '0;
            en_q        <= 1'b0;
            ar_q        <= 1'b0;
            ie_q        <= 1'b0;
            match_q     <= 1'b0;
            presc_q     <= '0;
        end else begin
            seg_q       <= seg_d;
            led_q       <= led_d;
            sw_meta_q   <= sw_meta_d;
            sw_s_q      <= sw_s_d;
            sw_stable_q <= sw_stable_d;
            deb_cnt_q   <= deb_cnt_d;
            chg_q       <= chg_d;
            tcnt_q      <= tcnt_d;
            tcmp_q      <= tcmp_d;
            en_q        <= en_d;
            ar_q        <= ar_d;
            ie_q        <= ie_d;
            match_q     <= match_d;
            presc_q     <= presc_d;
        end
    end

    assign seg_data = seg_q;
    assign led      = led_q;
    assign irq      = match_q & ie_q;

endmodule

// File: tb/tb_mmio_periph_hub.sv
// Bench for mmio_periph_hub: directed scenarios plus random traffic, with every
// cycle's outputs predicted by a behavioural model and checked from a queue.
module tb_mmio_periph_hub;

    localparam int DEB = 4;
    localparam int DIV = 2;
    localparam logic [31:0] IO  = 32'hFFFF_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, dram_rdata, rdata, dram_wdata, seg_data;
    logic        mem_we, dram_we, irq;
    logic [13:0] dram_addr;
    logic [23:0] switch, led;

    mmio_periph_hub #(
        .DEB_CYCLES(DEB),
        .TMR_DIV   (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .mem_we    (mem_we),
        .rdata     (rdata),
        .dram_rdata(dram_rdata),
        .dram_addr (dram_addr),
        .dram_we   (dram_we),
        .dram_wdata(dram_wdata),
        .switch    (switch),
        .led       (led),
        .seg_data  (seg_data),
        .irq       (irq)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // scoreboard: {cycle[31:0], signal id[3:0], expected value[31:0]}
    logic [67:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_seg, m_tcnt, m_tcmp;
    logic [23:0] m_led, m_stable, m_sw1, m_sw2;
    logic        m_chg, m_en, m_ar, m_ie, m_match;
    int          m_run, m_en_cycles;
    logic [23:0] sw_cur = '0;

    function automatic string sig_name(input logic [3:0] s);
        case (s)
            4'd0: return "rdata";
            4'd1: return "dram_we";
            4'd2: return "dram_addr";
            4'd3: return "dram_wdata";
            4'd4: return "led";
            4'd5: return "seg_data";
            default: return "irq";
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] a);
        return a[31:12] == IO[31:12];
    endfunction

    function automatic logic is_dram(input logic [31:0] a);
        return !is_io(a) && a >= 32'h0000_4000 && a < 32'h0001_4000;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (is_io(a)) begin
            case (a[11:0])
                12'h000: return m_seg;
                12'h060: return {8'd0, m_led};
                12'h070: return {8'd0, m_stable};
                12'h074: return {31'd0, m_chg};
                12'h080: return m_tcnt;
                12'h084: return m_tcmp;
                12'h088: return {23'd0, m_match, 5'd0, m_ie, m_ar, m_en};
                default: return 32'd0;
            endcase
        end
        if (is_dram(a)) return dram_rdata;
        return 32'd0;
    endfunction

    task automatic push(input int sig, input logic [31:0] v);
        exp_q.push_back({32'(cyc_cnt), 4'(sig), v});
    endtask

    // Advance the model across one clock edge using the inputs applied this cycle.
    task automatic model_update();
        logic        w, tick, hit;
        logic [11:0] off;
        logic [23:0] s;
        if (rst) begin
            m_seg = 0; m_led = 0; m_stable = 0; m_chg = 0; m_sw1 = 0; m_sw2 = 0;
            m_tcnt = 0; m_tcmp = 0; m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
            m_run = 1; m_en_cycles = 0;
            return;
        end
        w   = mem_we && is_io(addr);
        off = addr[11:0];
        // a synchronised value is accepted once it has been seen for DEB cycles
        s = m_sw2;
        if (m_run >= DEB && s != m_stable) begin
            m_stable = s;
            m_chg    = 1'b1;
        end else if (w && off == 12'h074 && wdata[0]) begin
            m_chg = 1'b0;
        end
        if (m_sw1 == s) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_sw2 = m_sw1;
        m_sw1 = switch;
        // timer ticks once every DIV enabled cycles
        tick = m_en && (m_en_cycles % DIV == DIV - 1);
        hit  = 1'b0;
        if (tick) begin
            if (m_tcnt == m_tcmp) begin
                hit = 1'b1;
                if (m_ar) m_tcnt = 0;
            end else begin
                m_tcnt = m_tcnt + 1;
            end
        end
        if (m_en) m_en_cycles++;
        if (w) begin
            case (off)
                12'h000: m_seg = wdata;
                12'h060: m_led = wdata[23:0];
                12'h080: m_tcnt = wdata;
                12'h084: m_tcmp = wdata;
                12'h088: begin
                    m_en = wdata[0]; m_ar = wdata[1]; m_ie = wdata[2];
                    if (wdata[8]) m_match = 1'b0;
                end
                default: ;
            endcase
        end
        if (hit) m_match = 1'b1;
        if (!m_en) m_en_cycles = 0;
    endtask

    // driver tasks
    task automatic drive(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        rst        = r;
        mem_we     = we;
        addr       = a;
        wdata      = d;
        switch     = sw_cur;
        dram_rdata = $urandom();
        if (!r) begin
            push(0, model_rdata(a));
            push(1, {31'd0, we && is_dram(a)});
            if (is_dram(a)) push(2, (a - 32'h0000_4000) >> 2);
            push(3, d);
            push(4, {8'd0, m_led});
            push(5, m_seg);
            push(6, {31'd0, m_match & m_ie});
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
        step();
    endtask

    task automatic ld(input logic [31:0] a);
        drive(1'b0, 1'b0, a, $urandom());
        step();
    endtask

    task automatic ld_exp(input logic [31:0] a, input logic [31:0] v);
        drive(1'b0, 1'b0, a, $urandom());
        push(0, v);
        step();
    endtask

    // monitor: compares every queued expectation in the cycle it was issued for
    always @(negedge clk) begin
        logic [67:0] it;
        logic [31:0] act;
        while (exp_q.size() > 0 && exp_q[0][67:36] <= 32'(cyc_cnt)) begin
            it = exp_q.pop_front();
            case (it[35:32])
                4'd0: act = rdata;
                4'd1: act = {31'd0, dram_we};
                4'd2: act = {18'd0, dram_addr};
                4'd3: act = dram_wdata;
                4'd4: act = {8'd0, led};
                4'd5: act = seg_data;
                default: act = {31'd0, irq};
            endcase
            checks++;
            if (it[67:36] != 32'(cyc_cnt)) begin
                failures++;
                $display("FAIL %s missed sample cyc=%0d", sig_name(it[35:32]), it[67:36]);
            end else if (act !== it[31:0]) begin
                failures++;
                $display("FAIL %s cyc=%0d actual=%h expected=%h",
                         sig_name(it[35:32]), cyc_cnt, act, it[31:0]);
            end
        end
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] offs[10];
        logic [31:0] edges[7];
        logic [23:0] one;
        int hold;
        offs  = '{12'h000, 12'h060, 12'h070, 12'h074, 12'h080,
                  12'h084, 12'h088, 12'h004, 12'h07C, 12'hFFC};
        edges = '{32'h0000_3FFC, 32'h0000_4000, 32'h0001_3FFC, 32'h0001_4000,
                  32'h0000_0000, 32'hFFFF_EFFC, 32'hFFFF_F000};
        one   = 24'd1;

        #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd0, 32'd0);
            step();
        end

        // reset state and register stores
        drive(1'b0, 1'b0, IO, 32'd0);
        push(0, 32'd0); push(4, 32'd0); push(5, 32'd0); push(6, 32'd0);
        step();
        st(IO, 32'h1234_5678);
        st(IO + 32'h060, 32'h00AB_CDEF);
        drive(1'b0, 1'b0, IO, 32'd0);
        push(5, 32'h1234_5678); push(0, 32'h1234_5678); push(1, 32'd0);
        step();
        drive(1'b0, 1'b0, IO + 32'h060, 32'd0);
        push(4, 32'h00AB_CDEF); push(0, 32'h00AB_CDEF);
        step();

        // DRAM store and unmapped load
        drive(1'b0, 1'b1, 32'h0000_4008, 32'hDEAD_BEEF);
        push(1, 32'd1); push(2, 32'd2); push(3, 32'hDEAD_BEEF);
        step();
        ld_exp(32'h0000_0100, 32'd0);

        // clean switch edge: visible exactly 6 cycles after the raw change
        sw_cur = 24'h000001;
        for (int t = 0; t < 6; t++) begin
            if (t == 5) ld_exp(IO + 32'h070, 32'd0);
            else ld(IO + 32'h070);
        end
        ld_exp(IO + 32'h070, 32'd1);
        ld_exp(IO + 32'h074, 32'd1);
        st(IO + 32'h074, 32'd1);
        ld_exp(IO + 32'h074, 32'd0);
        // 3-cycle glitch is rejected
        sw_cur = 24'h000003;
        for (int t = 0; t < 3; t++) ld(IO + 32'h070);
        sw_cur = 24'h000001;
        for (int t = 0; t < 10; t++) ld(IO + 32'h070);
        ld_exp(IO + 32'h070, 32'd1);
        ld_exp(IO + 32'h074, 32'd0);

        // timer: TCMP=3, auto-reload with interrupt enabled
        st(IO + 32'h084, 32'd3);
        st(IO + 32'h088, 32'h7);
        for (int t = 1; t <= 8; t++) ld_exp(IO + 32'h080, 32'((t - 1) / 2));
        drive(1'b0, 1'b1, IO + 32'h088, 32'h107);
        push(6, 32'd1);
        step();
        drive(1'b0, 1'b1, IO + 32'h080, 32'd100);
        push(6, 32'd0);
        step();
        st(IO + 32'h084, 32'd101);
        ld_exp(IO + 32'h080, 32'd100);
        ld_exp(IO + 32'h080, 32'd101);
        st(IO + 32'h088, 32'h107);
        drive(1'b0, 1'b0, IO + 32'h088, 32'd0);
        push(0, 32'h107); push(6, 32'd1);
        step();

        // reset mid-debounce with the timer running
        sw_cur = 24'h000000;
        for (int t = 0; t < 3; t++) ld(IO + 32'h080);
        drive(1'b1, 1'b0, IO, 32'd0);
        step();
        drive(1'b0, 1'b0, IO + 32'h070, 32'd0);
        push(0, 32'd0); push(4, 32'd0); push(5, 32'd0); push(6, 32'd0);
        step();
        for (int i = 0; i < 7; i++) ld_exp(IO + offs[i], 32'd0);
        for (int t = 0; t < 6; t++) ld_exp(IO + 32'h080, 32'd0);

        // random traffic
        st(IO + 32'h084, $urandom_range(0, 12));
        st(IO + 32'h088, {23'd0, 1'b0, 5'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
                sw_cur = sw_cur ^ (one << $urandom_range(0, 23));
                hold = $urandom_range(1, 10);
            end else begin
                hold--;
            end
            case ($urandom_range(0, 9))
                0: ld(IO + offs[$urandom_range(0, 9)]);
                1: st(IO, $urandom());
                2: st(IO + 32'h060, $urandom());
                3: st(IO + 32'h084, $urandom_range(0, 15));
                4: st(IO + offs[$urandom_range(2, 3) + 5 * $urandom_range(0, 1)], $urandom());
                5: st(IO + 32'h080, $urandom_range(0, 20));
                6: st(IO + 32'h088, {23'd0, 1'($urandom_range(0, 1)), 5'd0,
                                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
                7: begin
                    drive(1'b0, 1'($urandom_range(0, 1)),
                          32'h0000_4000 + ($urandom_range(0, 16383) << 2) + $urandom_range(0, 3),
                          $urandom());
                    step();
                end
                8: begin
                    drive(1'b0, 1'($urandom_range(0, 1)), edges[$urandom_range(0, 6)], $urandom());
                    step();
                end
                default: begin
                    logic [31:0] ra;
                    ra = $urandom();
                    drive(1'b0, 1'(!is_io(ra) && $urandom_range(0, 1) == 1), ra, $urandom());
                    step();
                end
            endcase
        end

        drive(1'b0, 1'b0, 32'd0, 32'd0);
        step();
        step();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
